// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the op encodings, the FSM state encodings and the default data width.
// The control-unit decoder imports this package so that it uses the same op codes.
package md_pkg;

    localparam int W_DEF     = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Signed ops take magnitudes of their operands; unsigned ops use them raw.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Handshake / operand bus between the control unit and the multiply/divide unit.
//   start, op, A, B    : operation request and operands (from DR1/DR2)
//   wr_hi, wr_lo, DW   : direct HI/LO load (MTHI/MTLO)
//   busy, done, hi, lo : status and architectural HI/LO
// master = requester (control unit), slave = mult_div_unit.
interface mult_div_unit_if #(
    parameter int W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] DW;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, A, B, wr_hi, wr_lo, DW,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, wr_hi, wr_lo, DW,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_iter_core.sv
// Iterative datapath for unsigned magnitudes: one shift-add (multiply) or one
// restoring-subtract (divide) step per enabled cycle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : initialise acc=0, sreg=a_mag, opnd=b_mag
//   step            : perform one iteration
//   is_div          : select restoring divide instead of shift-add multiply
//   a_mag, b_mag    : unsigned operand magnitudes
//   acc_out         : multiply: product high half; divide: remainder
//   sreg_out        : multiply: product low half;  divide: quotient
module md_iter_core #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a_mag,
    input  logic [W-1:0] b_mag,
    output logic [W-1:0] acc_out,
    output logic [W-1:0] sreg_out
);

    // acc carries one extra bit so the multiply add never loses its carry.
    logic [W:0]   acc_reg, acc_next;
    logic [W-1:0] sreg_reg, sreg_next;
    logic [W-1:0] opnd_reg;

    logic [W:0]   sum;
    logic [W:0]   rem_sh;
    logic [W+1:0] diff;

    always_comb begin
        sum       = acc_reg + {1'b0, opnd_reg};
        // Restoring divide: shift the next dividend bit into the partial remainder.
        rem_sh    = {acc_reg[W-1:0], sreg_reg[W-1]};
        // Two guard bits so a shifted remainder >= 2^W still yields a correct borrow.
        diff      = {1'b0, rem_sh} - {2'b00, opnd_reg};
        acc_next  = acc_reg;
        sreg_next = sreg_reg;
        if (is_div) begin
            if (!diff[W+1]) begin
                acc_next  = diff[W:0];
                sreg_next = {sreg_reg[W-2:0], 1'b1};
            end else begin
                acc_next  = rem_sh;
                sreg_next = {sreg_reg[W-2:0], 1'b0};
            end
        end else begin
            // Right-shifting {acc, sreg}: multiplier bits leave sreg while
            // product bits fill it from the top.
            if (sreg_reg[0]) begin
                acc_next  = {1'b0, sum[W:1]};
                sreg_next = {sum[0], sreg_reg[W-1:1]};
            end else begin
                acc_next  = {1'b0, acc_reg[W:1]};
                sreg_next = {acc_reg[0], sreg_reg[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            sreg_reg <= '0;
            opnd_reg <= '0;
        end else if (load) begin
            acc_reg  <= '0;
            sreg_reg <= a_mag;
            opnd_reg <= b_mag;
        end else if (step) begin
            acc_reg  <= acc_next;
            sreg_reg <= sreg_next;
        end
    end

    assign acc_out  = acc_reg[W-1:0];
    assign sreg_out = sreg_reg;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// A start accepted in IDLE runs W iterations in CALC, then FIX applies sign
// correction and writes HI/LO with a one-cycle done pulse: result is visible
// 33 edges after the start-sampling edge for every op.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mult_div_unit_if slave (start/op/A/B, wr_hi/wr_lo/DW, busy/done/hi/lo)
module mult_div_unit
    import md_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_div_unit_if.slave    bus
);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    op_e                op_reg;
    logic [W-1:0]       a_reg;
    logic               neg_reg;      // product / quotient must be negated
    logic               a_sign_reg;   // remainder takes the dividend's sign
    logic               b_zero_reg;
    logic [W-1:0]       hi_reg, lo_reg;
    logic               done_reg;

    logic               start_accept;
    logic               hilo_wr;
    logic               core_step;
    logic               fix;

    logic               a_neg, b_neg;
    logic [W-1:0]       a_mag, b_mag;
    logic [W-1:0]       core_acc, core_sreg;
    logic [2*W-1:0]     product, product_fix;
    logic [W-1:0]       quot_fix, rem_fix;
    logic               is_div;

    // Operand conditioning for the request presented this cycle.
    always_comb begin
        a_neg = op_is_signed(bus.op) && bus.A[W-1];
        b_neg = op_is_signed(bus.op) && bus.B[W-1];
        a_mag = a_neg ? (~bus.A + 1'b1) : bus.A;
        b_mag = b_neg ? (~bus.B + 1'b1) : bus.B;
    end

    assign is_div = op_is_div(op_reg);

    md_iter_core #(.W(W)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_accept),
        .step     (core_step),
        .is_div   (is_div),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .acc_out  (core_acc),
        .sreg_out (core_sreg)
    );

    // Sign correction of the raw magnitude results.
    always_comb begin
        product     = {core_acc, core_sreg};
        product_fix = neg_reg ? (~product + 1'b1) : product;
        quot_fix    = neg_reg ? (~core_sreg + 1'b1) : core_sreg;
        rem_fix     = a_sign_reg ? (~core_acc + 1'b1) : core_acc;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state and control strobes
    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        hilo_wr      = 1'b0;
        core_step    = 1'b0;
        fix          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    start_accept = 1'b1;
                    state_next   = S_CALC;
                end else begin
                    // MTHI/MTLO only when no op is being launched.
                    hilo_wr = 1'b1;
                end
            end
            S_CALC: begin
                core_step = 1'b1;
                if (cnt_reg == CNT_W'(W - 1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                fix        = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operation context, iteration counter, HI/LO and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            op_reg     <= OP_MULT;
            a_reg      <= '0;
            neg_reg    <= 1'b0;
            a_sign_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (start_accept) begin
                op_reg     <= op_e'(bus.op);
                a_reg      <= bus.A;
                neg_reg    <= a_neg ^ b_neg;
                a_sign_reg <= a_neg;
                b_zero_reg <= (bus.B == '0);
                cnt_reg    <= '0;
            end else if (core_step) begin
                cnt_reg <= cnt_reg + 1'b1;
            end

            if (hilo_wr) begin
                if (bus.wr_hi) begin
                    hi_reg <= bus.DW;
                end
                if (bus.wr_lo) begin
                    lo_reg <= bus.DW;
                end
            end

            if (fix) begin
                done_reg <= 1'b1;
                if (is_div) begin
                    if (b_zero_reg) begin
                        // Divide by zero: dividend passes to HI, LO saturates to ones.
                        hi_reg <= a_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end
                end else begin
                    hi_reg <= product_fix[2*W-1:W];
                    lo_reg <= product_fix[W-1:0];
                end
            end
        end
    end

    assign bus.busy = (state_reg != S_IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mult_div_unit_if #(.W(W)) bus ();

    mult_div_unit #(.W(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and let the start-sampling edge (E0) pass.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Run to edge E33 given edges already elapsed after E0; check handshake timing.
    task automatic wait_done(input string tag, input int elapsed);
        for (int i = elapsed; i < 32; i++) tick();
        check({tag, " busy@E32"}, W'(bus.busy), W'(1));
        check({tag, " done@E32"}, W'(bus.done), W'(0));
        tick();
        check({tag, " done@E33"}, W'(bus.done), W'(1));
        check({tag, " busy@E33"}, W'(bus.busy), W'(0));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        start_op(op, a, b);
        wait_done(tag, 0);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
        $display("op %0d A=%h B=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
        tick();
        check({tag, " done pulse end"}, W'(bus.done), W'(0));
    endtask

    initial begin
        logic saw_done;
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.DW    = '0;
        tick();
        tick();
        rst_n = 1'b1;

        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", W'(bus.busy), W'(0));
        check("reset done", W'(bus.done), W'(0));

        // MTHI, then both written in one cycle
        bus.wr_hi = 1'b1; bus.DW = 32'h0000_1234;
        tick();
        bus.wr_hi = 1'b0;
        check("mthi hi", bus.hi, 32'h0000_1234);
        check("mthi lo", bus.lo, 32'h0);
        $display("mthi DW=00001234 -> hi=%h", bus.hi);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.DW = 32'h0000_0055;
        tick();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        check("mthi+mtlo hi", bus.hi, 32'h55);
        check("mthi+mtlo lo", bus.lo, 32'h55);
        $display("mthi+mtlo DW=00000055 -> hi=%h lo=%h", bus.hi, bus.lo);

        // MTLO together with start: ignored, op launches; MTHI while busy: ignored
        bus.wr_lo = 1'b1; bus.DW = 32'hDEAD_0000;
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        bus.wr_lo = 1'b0;
        check("mtlo+start lo", bus.lo, 32'h55);
        check("mtlo+start busy", W'(bus.busy), W'(1));
        bus.wr_hi = 1'b1; bus.DW = 32'hBEEF_0000;
        tick();
        tick();
        bus.wr_hi = 1'b0;
        check("mthi busy hi", bus.hi, 32'h55);
        wait_done("mult -3*5", 2);
        check("mult -3*5 hi", bus.hi, 32'hFFFF_FFFF);
        check("mult -3*5 lo", bus.lo, 32'hFFFF_FFF1);
        $display("op 0 A=fffffffd B=00000005 -> hi=%h lo=%h", bus.hi, bus.lo);
        tick();
        check("mult -3*5 done pulse end", W'(bus.done), W'(0));

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult big", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div -16/0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // DIVU 100/7 with a start pulse at cycle 10 and operand changes mid-op
        start_op(OP_DIVU, 32'd100, 32'd7);
        for (int i = 1; i < 10; i++) tick();
        start_op(OP_MULT, 32'd3, 32'd4);
        bus.A = 32'd55; bus.B = 32'd66; bus.op = OP_DIV;
        check("ignored start busy", W'(bus.busy), W'(1));
        wait_done("divu 100/7", 10);
        check("divu 100/7 hi", bus.hi, 32'd2);
        check("divu 100/7 lo", bus.lo, 32'd14);
        $display("op 3 A=00000064 B=00000007 -> hi=%h lo=%h", bus.hi, bus.lo);

        // Back-to-back: start in the done cycle is accepted
        start_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        check("b2b done pulse end", W'(bus.done), W'(0));
        check("b2b busy", W'(bus.busy), W'(1));
        wait_done("b2b multu", 0);
        check("b2b multu hi", bus.hi, 32'h1);
        check("b2b multu lo", bus.lo, 32'h0);
        $display("op 1 A=00010000 B=00010000 -> hi=%h lo=%h", bus.hi, bus.lo);
        tick();

        // Reset mid-operation at cycle 15
        start_op(OP_MULT, 32'h0001_2345, 32'h0000_0100);
        for (int i = 1; i < 15; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midreset hi", bus.hi, 32'h0);
        check("midreset lo", bus.lo, 32'h0);
        check("midreset busy", W'(bus.busy), W'(0));
        check("midreset done", W'(bus.done), W'(0));
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("midreset no result", W'(saw_done), W'(0));
        check("midreset hi later", bus.hi, 32'h0);
        $display("reset mid-op -> hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);

        run_op("post-reset mult", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
